// File: rtl/ex_mem_buffer_pkg.sv
// Shared types and field positions for the EX/MEM pipeline buffer.
// Control vector layout (bit 6..0):
//   {reg_write, mem_to_reg, mem_read, mem_write, branch, uncond_branch, flag_unused}
package ex_mem_buffer_pkg;

    localparam int unsigned WORD_W = 64;
    localparam int unsigned CTRL_W = 7;
    localparam int unsigned REG_W  = 5;

    // Control bit positions consumed inside the buffer
    localparam int unsigned CTRL_BRANCH = 2;
    localparam int unsigned CTRL_UNCOND = 1;

    // Occupancy states; encoding equals the number of held entries
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } occ_state_e;

    // One buffered execute-stage result
    typedef struct packed {
        logic [WORD_W-1:0] alu_result;
        logic              zero;
        logic [WORD_W-1:0] write_data;
        logic [WORD_W-1:0] branch_target;
        logic [CTRL_W-1:0] ctrl;
        logic [REG_W-1:0]  write_reg;
    } entry_t;

endpackage

// File: rtl/ex_mem_entry.sv
// Load-enabled register holding one EX/MEM entry.
// Ports: clk, reset (sync, active-high), i_clear (sync clear), i_load, i_d -> o_q.
module ex_mem_entry
    import ex_mem_buffer_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  logic   i_clear,
    input  logic   i_load,
    input  entry_t i_d,
    output entry_t o_q
);

    entry_t r_q;

    // Clear wins over load so a flushed slot never holds stale data
    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/ex_mem_buffer.sv
// Two-entry EX/MEM pipeline buffer with valid/ready handshakes on both sides.
// Ports: clk, reset (sync, active-high); execute side in_valid/in_ready plus
// alu_result, zero, write_data, branch_target, ctrl_in, write_reg_in; flush;
// memory side out_valid/out_ready plus out_* head fields, pc_src, occupancy.
module ex_mem_buffer
    import ex_mem_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = 2
)
(
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] alu_result,
    input  logic              zero,
    input  logic [WORD_W-1:0] write_data,
    input  logic [WORD_W-1:0] branch_target,
    input  logic [CTRL_W-1:0] ctrl_in,
    input  logic [REG_W-1:0]  write_reg_in,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_alu_result,
    output logic [WORD_W-1:0] out_write_data,
    output logic [WORD_W-1:0] out_branch_target,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [REG_W-1:0]  out_write_reg,
    output logic              pc_src,
    output logic [1:0]        occupancy
);

    occ_state_e r_state;
    occ_state_e w_state_nxt;
    logic       r_out_valid;
    logic       r_in_ready;

    logic       w_push;
    logic       w_pop;
    logic       w_load0;
    logic       w_load1;
    logic       w_sel_in0;
    logic       w_clear;

    entry_t     w_in_entry;
    entry_t     w_d0;
    entry_t     w_head;
    entry_t     w_tail;

    assign w_in_entry = '{
        alu_result:    alu_result,
        zero:          zero,
        write_data:    write_data,
        branch_target: branch_target,
        ctrl:          ctrl_in,
        write_reg:     write_reg_in
    };

    assign w_push = in_valid && r_in_ready;
    assign w_pop  = r_out_valid && out_ready;

    // State register; handshake flags are registered from the next state so
    // in_ready has no combinational path from out_ready
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_EMPTY;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_out_valid <= (w_state_nxt != ST_EMPTY);
            r_in_ready  <= (2'(w_state_nxt) < 2'(DEPTH));
        end
    end

    // Next state and slot control; pop is applied before push
    always_comb begin
        w_state_nxt = r_state;
        w_load0     = 1'b0;
        w_load1     = 1'b0;
        w_sel_in0   = 1'b1;
        w_clear     = 1'b0;
        if (flush) begin
            w_state_nxt = ST_EMPTY;
            w_clear     = 1'b1;
        end else begin
            unique case (r_state)
                ST_EMPTY: begin
                    if (w_push) begin
                        w_state_nxt = ST_ONE;
                        w_load0     = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (w_push && w_pop) begin
                        w_load0 = 1'b1;
                    end else if (w_push) begin
                        w_state_nxt = ST_FULL;
                        w_load1     = 1'b1;
                    end else if (w_pop) begin
                        w_state_nxt = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    // No push possible here: in_ready is low
                    if (w_pop) begin
                        w_state_nxt = ST_ONE;
                        w_load0     = 1'b1;
                        w_sel_in0   = 1'b0;
                    end
                end
                default: begin
                    w_state_nxt = ST_EMPTY;
                    w_clear     = 1'b1;
                end
            endcase
        end
    end

    // Head slot takes the new entry or the advancing tail entry
    assign w_d0 = w_sel_in0 ? w_in_entry : w_tail;

    ex_mem_entry u_head (
        .clk     (clk),
        .reset   (reset),
        .i_clear (w_clear),
        .i_load  (w_load0),
        .i_d     (w_d0),
        .o_q     (w_head)
    );

    ex_mem_entry u_tail (
        .clk     (clk),
        .reset   (reset),
        .i_clear (w_clear),
        .i_load  (w_load1),
        .i_d     (w_in_entry),
        .o_q     (w_tail)
    );

    assign in_ready          = r_in_ready;
    assign out_valid         = r_out_valid;
    assign occupancy         = 2'(r_state);
    assign out_alu_result    = w_head.alu_result;
    assign out_write_data    = w_head.write_data;
    assign out_branch_target = w_head.branch_target;
    assign out_ctrl          = w_head.ctrl;
    assign out_write_reg     = w_head.write_reg;

    // Branch decision from the captured head fields
    assign pc_src = r_out_valid &&
                    (w_head.ctrl[CTRL_UNCOND] || (w_head.ctrl[CTRL_BRANCH] && w_head.zero));

endmodule

// File: tb/tb_ex_mem_buffer.sv
// Directed self-checking bench for ex_mem_buffer.
module tb_ex_mem_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] alu_result;
    logic        zero;
    logic [63:0] write_data;
    logic [63:0] branch_target;
    logic [6:0]  ctrl_in;
    logic [4:0]  write_reg_in;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_alu_result;
    logic [63:0] out_write_data;
    logic [63:0] out_branch_target;
    logic [6:0]  out_ctrl;
    logic [4:0]  out_write_reg;
    logic        pc_src;
    logic [1:0]  occupancy;

    int errors = 0;
    int checks = 0;

    localparam logic [6:0] C_RW   = 7'b1000000;
    localparam logic [6:0] C_CBZ  = 7'b0000100;
    localparam logic [6:0] C_B    = 7'b0000010;
    localparam logic [6:0] C_STUR = 7'b0001000;

    ex_mem_buffer #(.DEPTH(2)) dut (
        .clk               (clk),
        .reset             (reset),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .alu_result        (alu_result),
        .zero              (zero),
        .write_data        (write_data),
        .branch_target     (branch_target),
        .ctrl_in           (ctrl_in),
        .write_reg_in      (write_reg_in),
        .flush             (flush),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_alu_result    (out_alu_result),
        .out_write_data    (out_write_data),
        .out_branch_target (out_branch_target),
        .out_ctrl          (out_ctrl),
        .out_write_reg     (out_write_reg),
        .pc_src            (pc_src),
        .occupancy         (occupancy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then settle before sampling
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [63:0] alu, input logic z, input logic [63:0] wd,
                         input logic [63:0] bt, input logic [6:0] c, input logic [4:0] wr);
        in_valid      = 1'b1;
        alu_result    = alu;
        zero          = z;
        write_data    = wd;
        branch_target = bt;
        ctrl_in       = c;
        write_reg_in  = wr;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        alu_result = '0; zero = 1'b0; write_data = '0; branch_target = '0;
        ctrl_in = '0; write_reg_in = '0;
        step(); step();
        reset = 1'b0;
        step();

        // Reset state
        check("rst_occ", 64'(occupancy), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_pc_src", 64'(pc_src), 64'd0);
        check("rst_alu", out_alu_result, 64'd0);
        check("rst_ctrl", 64'(out_ctrl), 64'd0);

        // ADD: result 25, visible one cycle after push
        drive(64'd25, 1'b0, 64'd0, 64'd0, C_RW, 5'd3);
        step();
        in_valid = 1'b0;
        check("add_valid", 64'(out_valid), 64'd1);
        check("add_alu", out_alu_result, 64'd25);
        check("add_pc_src", 64'(pc_src), 64'd0);
        check("add_wreg", 64'(out_write_reg), 64'd3);
        check("add_ctrl", 64'(out_ctrl), 64'(C_RW));
        check("add_occ", 64'(occupancy), 64'd1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("add_pop_occ", 64'(occupancy), 64'd0);
        check("add_pop_valid", 64'(out_valid), 64'd0);

        // CBZ taken
        drive(64'd0, 1'b1, 64'd0, 64'h40, C_CBZ, 5'd0);
        step();
        in_valid = 1'b0;
        check("cbz_pc_src", 64'(pc_src), 64'd1);
        check("cbz_target", out_branch_target, 64'h40);
        out_ready = 1'b1;
        step();
        // CBZ not taken (zero clear), popped the same cycle it is pushed? no: queue empty
        drive(64'd7, 1'b0, 64'd0, 64'h80, C_CBZ, 5'd0);
        out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        check("cbz_nt_pc_src", 64'(pc_src), 64'd0);
        out_ready = 1'b1;
        step();
        // Unconditional branch ignores zero
        drive(64'd0, 1'b0, 64'd0, 64'h100, C_B, 5'd0);
        out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        check("b_pc_src", 64'(pc_src), 64'd1);
        check("b_target", out_branch_target, 64'h100);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("b_pop_pc_src", 64'(pc_src), 64'd0);

        // Backpressure: fill with 5 then 10
        drive(64'd5, 1'b0, 64'd0, 64'd0, C_RW, 5'd1);
        step();
        drive(64'd10, 1'b0, 64'hAB, 64'd0, C_STUR, 5'd2);
        step();
        check("bp_occ", 64'(occupancy), 64'd2);
        check("bp_in_ready", 64'(in_ready), 64'd0);
        check("bp_head", out_alu_result, 64'd5);
        // Push attempt while full is ignored; head stays stable
        drive(64'd99, 1'b0, 64'd0, 64'd0, C_RW, 5'd9);
        step();
        in_valid = 1'b0;
        check("bp_full_occ", 64'(occupancy), 64'd2);
        check("bp_hold_alu", out_alu_result, 64'd5);
        check("bp_hold_wreg", 64'(out_write_reg), 64'd1);
        out_ready = 1'b1;
        step();
        check("bp_second_alu", out_alu_result, 64'd10);
        check("bp_second_wd", out_write_data, 64'hAB);
        check("bp_second_occ", 64'(occupancy), 64'd1);
        check("bp_second_ready", 64'(in_ready), 64'd1);
        step();
        out_ready = 1'b0;
        check("bp_drain_occ", 64'(occupancy), 64'd0);
        check("bp_drain_valid", 64'(out_valid), 64'd0);

        // Simultaneous push/pop at occupancy 1
        drive(64'd15, 1'b0, 64'd0, 64'd0, C_RW, 5'd4);
        step();
        check("sim_pre_head", out_alu_result, 64'd15);
        drive(64'd30, 1'b0, 64'd0, 64'd0, C_RW, 5'd5);
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        out_ready = 1'b0;
        check("sim_occ", 64'(occupancy), 64'd1);
        check("sim_head", out_alu_result, 64'd30);
        check("sim_wreg", 64'(out_write_reg), 64'd5);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // Flush at occupancy 2 dominates a concurrent push
        drive(64'd1, 1'b0, 64'd0, 64'd0, C_RW, 5'd1);
        step();
        drive(64'd2, 1'b0, 64'd0, 64'd0, C_RW, 5'd2);
        step();
        check("fl_pre_occ", 64'(occupancy), 64'd2);
        drive(64'd3, 1'b0, 64'd0, 64'd0, C_RW, 5'd3);
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        check("fl_occ", 64'(occupancy), 64'd0);
        check("fl_valid", 64'(out_valid), 64'd0);
        check("fl_in_ready", 64'(in_ready), 64'd1);

        // Reset mid-stall discards held entries
        drive(64'd7, 1'b1, 64'h77, 64'h200, C_B, 5'd7);
        step();
        drive(64'd8, 1'b0, 64'h88, 64'h300, C_RW, 5'd8);
        step();
        in_valid = 1'b0;
        check("rm_pre_occ", 64'(occupancy), 64'd2);
        check("rm_pre_pc_src", 64'(pc_src), 64'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rm_occ", 64'(occupancy), 64'd0);
        check("rm_valid", 64'(out_valid), 64'd0);
        check("rm_pc_src", 64'(pc_src), 64'd0);
        check("rm_alu", out_alu_result, 64'd0);
        check("rm_wd", out_write_data, 64'd0);
        check("rm_bt", out_branch_target, 64'd0);
        check("rm_ctrl", 64'(out_ctrl), 64'd0);
        check("rm_wreg", 64'(out_write_reg), 64'd0);
        step();
        check("rm_in_ready", 64'(in_ready), 64'd1);
        check("rm_idle_occ", 64'(occupancy), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ex_mem_buffer.md
EX_MEM_BUFFER -- requirements
Module: ex_mem_buffer

Interface
REQ-001 SHALL provide parameter DEPTH, default 2, meaning entry count; only 2 is supported.
REQ-002 SHALL have clk  input  1  the one clock; all state updates on the rising edge.
REQ-003 SHALL have reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have in_valid  input  1  execute stage presents an entry this cycle.
REQ-005 SHALL have in_ready  output  1  buffer accepts an entry this cycle.
REQ-006 SHALL have alu_result  input  `WORD  ALU result (address for LDUR/STUR).
REQ-007 SHALL have zero  input  1  ALU zero flag.
REQ-008 SHALL have write_data  input  `WORD  store data for STUR.
REQ-009 SHALL have branch_target  input  `WORD  computed PC + offset.
REQ-010 SHALL have ctrl_in  input  7  {reg_write, mem_to_reg, mem_read, mem_write, branch, uncond_branch, flag_unused=0}.
REQ-011 SHALL have write_reg_in  input  5  destination register number.
REQ-012 SHALL have flush  input  1  discard all held entries.
REQ-013 SHALL have out_valid  output  1  head entry is valid.
REQ-014 SHALL have out_ready  input  1  memory stage consumes the head entry.
REQ-015 SHALL have out_alu_result, out_write_data, out_branch_target  output  `WORD each  head-entry fields.
REQ-016 SHALL have out_ctrl  output  7 and out_write_reg  output  5  head-entry fields.
REQ-017 SHALL have pc_src  output  1  head-entry branch decision.
REQ-018 SHALL have occupancy  output  2  number of held entries (0..2).

Function
REQ-019 SHALL push when in_valid && in_ready, pop when out_valid && out_ready; both may occur in one cycle.
REQ-020 SHALL drive in_ready = (occupancy < 2) from registered state only, with no combinational path from out_ready.
REQ-021 SHALL make a pushed entry visible on out_* the cycle after the push edge (latency 1).
REQ-022 SHALL pop before push in a simultaneous cycle: at occupancy 1 it remains 1 with the new entry at head; at occupancy 2 no push occurs.
REQ-023 SHALL preserve FIFO order; the second entry moves to head on the cycle after the head pops.
REQ-024 SHALL capture zero with its entry and compute pc_src = out_valid && (uncond_branch || (branch && zero)) combinationally from head fields.
REQ-025 SHALL hold all out_* fields stable while out_valid && !out_ready.
REQ-026 SHALL on flush set occupancy to 0 next cycle; flush dominates any push or pop in the same cycle.
REQ-027 SHALL ignore in_valid when in_ready is 0, leaving state unchanged.
REQ-028 SHALL implement states EMPTY(0), ONE(1) and FULL(2) with the following transitions: push-only +1, pop-only -1, push+pop unchanged, flush -> EMPTY.

Reset
REQ-029 SHALL on reset set occupancy 0, out_valid 0, pc_src 0, and all out_* data/ctrl fields 0.
REQ-030 SHALL make reset dominate flush, push and pop; a reset mid-stall discards held entries, and in_ready is 1 the cycle after reset deasserts.

Structure
REQ-031 SHALL take `WORD, ALUOp codes, opcode macros, and the ctrl bit positions (new `CTRL_* defines) from definitions.vh.
REQ-032 SHALL use one sub-module, ex_mem_entry, which is a load-enabled register holding one entry, instantiated twice.

Verification
REQ-033 SHALL cover ADD: push alu_result=25, zero=0, ctrl reg_write -> next cycle out_alu_result=25, pc_src=0.
REQ-034 SHALL cover CBZ taken: push alu_result=0, zero=1, branch=1, branch_target=0x40 -> pc_src=1, out_branch_target=0x40.
REQ-035 SHALL cover backpressure: out_ready=0, push SUB(5) then AND(10) -> occupancy 2, in_ready=0, head=5; set out_ready=1 -> 5 then 10 in order.
REQ-036 SHALL cover simultaneous push/pop: at occupancy 1 (head=15), push 30 with out_ready=1 -> occupancy stays 1, head=30 next cycle.
REQ-037 SHALL cover flush with push: at occupancy 2, assert flush with in_valid=1 -> occupancy 0, out_valid 0 next cycle.
REQ-038 SHALL cover reset mid-operation: at occupancy 2, assert reset one cycle -> all outputs 0 and in_ready=1 after deassertion.
